snake_move: RTL

Snake body engine for the game core. On each step strobe it advances the head one cell in the requested direction, scans the body for self-collision, detects food pickup against the current point, and commits the move. It sits directly upstream of generate_point: its one-cycle `colision` pulse requests a new point, and it consumes that block's `seed_x_out`/`seed_y_out`/`seed_rdy` as the food location.

---
 rtl/snake_pkg.sv | 68 ++++++
 rtl/snake_body_buf.sv | 69 ++++++
 rtl/snake_move.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body engine.
//   game_mode     : MENU holds the snake at its initial state, GAME enables stepping
//   dir_t         : movement directions (UP decreases y, LEFT decreases x)
//   cell_t        : one board cell {x, y}, 5 bits each
//   snake_state_e : body engine FSM states
//   opposite()    : direction that would reverse the snake onto itself
//   step_cell()   : neighbour cell in a direction, wrapping on the 32x32 board
//   init_cell()   : cell k positions behind the head in the initial body
package snake_pkg;

  typedef enum logic {
    MENU = 1'b0,
    GAME = 1'b1
  } game_mode;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT,
    ST_DEAD
  } snake_state_e;

  localparam cell_t INIT_HEAD = '{x: 5'd16, y: 5'd16};
  localparam dir_t  INIT_DIR  = RIGHT;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  // 5-bit arithmetic gives the board wrap for free.
  function automatic cell_t step_cell(input cell_t c, input dir_t d);
    cell_t n;
    n = c;
    case (d)
      UP:      n.y = c.y - 5'd1;
      DOWN:    n.y = c.y + 5'd1;
      LEFT:    n.x = c.x - 5'd1;
      default: n.x = c.x + 5'd1;
    endcase
    return n;
  endfunction

  // The initial body lies to the left of the head because it starts heading RIGHT.
  function automatic cell_t init_cell(input int k);
    cell_t c;
    c.x = INIT_HEAD.x - 5'(k);
    c.y = INIT_HEAD.y;
    return c;
  endfunction

endpackage

// File: rtl/snake_body_buf.sv
// Circular body buffer. Entry k from the head lives at (head_ptr - k) mod MAX_LEN,
// so pushing a new head needs only a pointer increment; the tail "pops" implicitly
// because the owner of the length simply stops looking at it.
//   clk_75, rst  : clock, async active-low reset
//   init_i       : synchronous re-initialise to the starting body
//   push_i       : write push_cell_i as the new head
//   scan_idx_i   : head-relative index for the combinational scan port
//   scan_cell_o  : body cell at scan_idx_i (same cycle)
//   rd_idx_i     : head-relative index for the external read port
//   rd_cell_o    : body cell at rd_idx_i, registered (1-cycle latency)
module snake_body_buf
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic                       clk_75,
  input  logic                       rst,
  input  logic                       init_i,
  input  logic                       push_i,
  input  cell_t                      push_cell_i,
  input  logic [$clog2(MAX_LEN)-1:0] scan_idx_i,
  output cell_t                      scan_cell_o,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx_i,
  output cell_t                      rd_cell_o
);

  localparam int IDX_W = $clog2(MAX_LEN);

  cell_t            mem_q [MAX_LEN];
  cell_t            rd_cell_q;
  logic [IDX_W-1:0] head_ptr_q;
  logic [IDX_W-1:0] push_addr;
  logic [IDX_W-1:0] scan_addr;
  logic [IDX_W-1:0] rd_addr;

  assign push_addr   = head_ptr_q + IDX_W'(1);
  assign scan_addr   = head_ptr_q - scan_idx_i;
  assign rd_addr     = head_ptr_q - rd_idx_i;
  assign scan_cell_o = mem_q[scan_addr];
  assign rd_cell_o   = rd_cell_q;

  // NOTE: the body is held in flops rather than a RAM macro, so it can take the
  // async reset; that makes the starting body valid from the first cycle out of reset.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_75 or negedge rst) begin
    if (!rst) begin
      head_ptr_q <= IDX_W'(INIT_LEN - 1);
      for (int i = 0; i < MAX_LEN; i++)
        mem_q[i] <= (i < INIT_LEN) ? init_cell(INIT_LEN - 1 - i) : '0;
    end else if (init_i) begin
      head_ptr_q <= IDX_W'(INIT_LEN - 1);
      for (int i = 0; i < MAX_LEN; i++)
        mem_q[i] <= (i < INIT_LEN) ? init_cell(INIT_LEN - 1 - i) : '0;
    end else if (push_i) begin
      // At full length push_addr is the tail slot, so the overwrite is the pop.
      mem_q[push_addr] <= push_cell_i;
      head_ptr_q       <= push_addr;
    end
  end

  // Sampled before any same-edge push lands, so reads during COMMIT see pre-commit data.
  always_ff @(posedge clk_75 or negedge rst) begin
    if (!rst) rd_cell_q <= '0;
    else      rd_cell_q <= mem_q[rd_addr];
  end

endmodule

// File: rtl/snake_move.sv
// Snake body engine. On a step strobe it moves the head one cell, scans the body
// one entry per cycle for self-collision, checks food pickup, then commits.
//   clk_75, rst          : clock, async active-low reset
//   mode                 : MENU re-initialises, GAME enables stepping
//   step, dir            : move strobe and requested direction
//   point_x/y, point_rdy : food cell and its valid flag
//   rd_idx -> rd_x/rd_y  : registered head-relative body read port
//   head_x/y, length     : committed head cell and body length
//   colision             : one-cycle pulse when food is eaten
//   dead                 : sticky self-collision flag
//   busy                 : high while a move is being scanned or committed
module snake_move
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic                       clk_75,
  input  logic                       rst,
  input  game_mode                   mode,
  input  logic                       step,
  input  dir_t                       dir,
  input  logic [4:0]                 point_x,
  input  logic [4:0]                 point_y,
  input  logic                       point_rdy,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [4:0]                 rd_x,
  output logic [4:0]                 rd_y,
  output logic [4:0]                 head_x,
  output logic [4:0]                 head_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       colision,
  output logic                       dead,
  output logic                       busy
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;

  snake_state_e     state_q;
  dir_t             heading_q;
  cell_t            head_q;
  cell_t            new_head_q;
  logic             eat_q;
  logic [IDX_W-1:0] scan_k_q;
  logic [IDX_W-1:0] scan_last_q;
  logic [LEN_W-1:0] length_q;
  logic             colision_q;
  logic             dead_q;
  logic             busy_q;

  dir_t  eff_dir;
  cell_t next_head;
  logic  next_eat;
  cell_t scan_cell;
  cell_t rd_cell;
  logic  scan_hit;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    eff_dir   = dir;
    if (dir == opposite(heading_q)) eff_dir = heading_q;
    next_head = step_cell(head_q, eff_dir);
    next_eat  = point_rdy && (next_head == {point_x, point_y});
  end

  assign scan_hit = (scan_cell == new_head_q);

  always_ff @(posedge clk_75 or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      heading_q   <= INIT_DIR;
      head_q      <= INIT_HEAD;
      new_head_q  <= '0;
      eat_q       <= 1'b0;
      scan_k_q    <= '0;
      scan_last_q <= '0;
      length_q    <= LEN_W'(INIT_LEN);
      colision_q  <= 1'b0;
      dead_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else if (mode == MENU) begin
      // MENU overrides every state, aborting any move in flight.
      state_q     <= ST_IDLE;
      heading_q   <= INIT_DIR;
      head_q      <= INIT_HEAD;
      eat_q       <= 1'b0;
      scan_k_q    <= '0;
      length_q    <= LEN_W'(INIT_LEN);
      colision_q  <= 1'b0;
      dead_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      colision_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (step) begin
            heading_q  <= eff_dir;
            new_head_q <= next_head;
            eat_q      <= next_eat;
            scan_k_q   <= '0;
            // Without food the tail vacates this step, so it is not compared.
            scan_last_q <= next_eat ? IDX_W'(length_q - LEN_W'(1))
                                    : IDX_W'(length_q - LEN_W'(2));
            state_q    <= ST_SCAN;
            busy_q     <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_hit) begin
            state_q <= ST_DEAD;
            dead_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (scan_k_q == scan_last_q) begin
            state_q <= ST_COMMIT;
          end else begin
            scan_k_q <= scan_k_q + IDX_W'(1);
          end
        end
        ST_COMMIT: begin
          head_q <= new_head_q;
          if (eat_q && (length_q < LEN_W'(MAX_LEN))) length_q <= length_q + LEN_W'(1);
          colision_q <= eat_q;
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
        ST_DEAD: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  snake_body_buf #(
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN)
  ) u_body (
    .clk_75     (clk_75),
    .rst        (rst),
    .init_i     (mode == MENU),
    .push_i     ((state_q == ST_COMMIT) && (mode == GAME)),
    .push_cell_i(new_head_q),
    .scan_idx_i (scan_k_q),
    .scan_cell_o(scan_cell),
    .rd_idx_i   (rd_idx),
    .rd_cell_o  (rd_cell)
  );

  assign rd_x     = rd_cell.x;
  assign rd_y     = rd_cell.y;
  assign head_x   = head_q.x;
  assign head_y   = head_q.y;
  assign length   = length_q;
  assign colision = colision_q;
  assign dead     = dead_q;
  assign busy     = busy_q;

endmodule
